// File: rtl/ps2_keypad_pkg.sv
// Shared constants, state encoding and the set-2 to hex keypad map
// for the PS/2 keypad receiver.
package ps2_keypad_pkg;

    localparam int TIMEOUT_CYCLES_DEF = 25000;

    localparam logic [7:0] SC_E0 = 8'hE0;
    localparam logic [7:0] SC_F0 = 8'hF0;

    localparam logic [7:0] SC_K0 = 8'h22;
    localparam logic [7:0] SC_K1 = 8'h16;
    localparam logic [7:0] SC_K2 = 8'h1E;
    localparam logic [7:0] SC_K3 = 8'h26;
    localparam logic [7:0] SC_K4 = 8'h15;
    localparam logic [7:0] SC_K5 = 8'h1D;
    localparam logic [7:0] SC_K6 = 8'h24;
    localparam logic [7:0] SC_K7 = 8'h1C;
    localparam logic [7:0] SC_K8 = 8'h1B;
    localparam logic [7:0] SC_K9 = 8'h23;
    localparam logic [7:0] SC_KA = 8'h1A;
    localparam logic [7:0] SC_KB = 8'h21;
    localparam logic [7:0] SC_KC = 8'h25;
    localparam logic [7:0] SC_KD = 8'h2D;
    localparam logic [7:0] SC_KE = 8'h2B;
    localparam logic [7:0] SC_KF = 8'h2A;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    typedef struct packed {
        logic       hit;
        logic [3:0] code;
    } key_map_t;

    function automatic key_map_t map_key(input logic [7:0] sc);
        key_map_t m;
        m.hit  = 1'b1;
        m.code = 4'h0;
        case (sc)
            SC_K0:   m.code = 4'h0;
            SC_K1:   m.code = 4'h1;
            SC_K2:   m.code = 4'h2;
            SC_K3:   m.code = 4'h3;
            SC_K4:   m.code = 4'h4;
            SC_K5:   m.code = 4'h5;
            SC_K6:   m.code = 4'h6;
            SC_K7:   m.code = 4'h7;
            SC_K8:   m.code = 4'h8;
            SC_K9:   m.code = 4'h9;
            SC_KA:   m.code = 4'hA;
            SC_KB:   m.code = 4'hB;
            SC_KC:   m.code = 4'hC;
            SC_KD:   m.code = 4'hD;
            SC_KE:   m.code = 4'hE;
            SC_KF:   m.code = 4'hF;
            default: m.hit  = 1'b0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ps2_keypad_if.sv
// PS/2 line inputs and decoded keypad state outputs.
// master = keypad decoder, slave = PS/2 source and key consumer.
interface ps2_keypad_if;
    logic        ps2_clk;
    logic        ps2_data;
    logic [15:0] keys;
    logic        key_event;
    logic [3:0]  key_code;
    logic        key_down;
    logic        frame_err;

    modport master (
        input  ps2_clk,
        input  ps2_data,
        output keys,
        output key_event,
        output key_code,
        output key_down,
        output frame_err
    );

    modport slave (
        output ps2_clk,
        output ps2_data,
        input  keys,
        input  key_event,
        input  key_code,
        input  key_down,
        input  frame_err
    );
endinterface

// File: rtl/ps2_frame_rx.sv
// PS/2 frame receiver: input sync, falling-edge detect, 11-bit frame
// FSM with odd-parity/stop checking and a mid-frame timeout.
module ps2_frame_rx
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       res,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       frame_err,
    output logic       par_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    rx_state_e     state_q;
    logic [2:0]    clk_sync_q;
    logic [1:0]    data_sync_q;
    logic [2:0]    bitcnt_q;
    logic [7:0]    shift_q;
    logic          par_q;
    logic [TW-1:0] tmo_q;
    logic          byte_valid_q;
    logic          frame_err_q;
    logic          par_err_q;

    logic fall;
    logic din;

    assign fall = clk_sync_q[2] & ~clk_sync_q[1];
    assign din  = data_sync_q[1];

    always_ff @(posedge clk) begin
        if (res) begin
            state_q      <= RX_IDLE;
            clk_sync_q   <= 3'b111;
            data_sync_q  <= 2'b11;
            bitcnt_q     <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            par_err_q    <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q  <= {data_sync_q[0], ps2_data};
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            par_err_q    <= 1'b0;
            if (fall) begin
                // An edge always wins over an expiring timeout
                tmo_q <= '0;
                unique case (state_q)
                    RX_IDLE: begin
                        if (!din) begin
                            state_q  <= RX_DATA;
                            bitcnt_q <= '0;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    RX_DATA: begin
                        shift_q  <= {din, shift_q[7:1]};
                        bitcnt_q <= bitcnt_q + 3'd1;
                        if (bitcnt_q == 3'd7) state_q <= RX_PARITY;
                    end
                    RX_PARITY: begin
                        par_q   <= din;
                        state_q <= RX_STOP;
                    end
                    RX_STOP: begin
                        state_q <= RX_IDLE;
                        if (din && (^{shift_q, par_q})) begin
                            byte_valid_q <= 1'b1;
                        end else begin
                            frame_err_q <= 1'b1;
                            par_err_q   <= 1'b1;
                        end
                    end
                endcase
            end else if (state_q != RX_IDLE) begin
                if (tmo_q == TMO_LAST) begin
                    frame_err_q <= 1'b1;
                    state_q     <= RX_IDLE;
                    tmo_q       <= '0;
                end else begin
                    tmo_q <= tmo_q + 1'b1;
                end
            end
        end
    end

    assign rx_byte    = shift_q;
    assign byte_valid = byte_valid_q;
    assign frame_err  = frame_err_q;
    assign par_err    = par_err_q;

endmodule

// File: rtl/ps2_keypad.sv
// PS/2 set-2 scancode decoder producing the 16-key hex keypad state
// plus make/break event pulses.
module ps2_keypad
    import ps2_keypad_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
    input logic        clk,
    input logic        res,
    ps2_keypad_if.master bus
);

    logic [7:0] rx_byte;
    logic       byte_valid;
    logic       par_err;

    ps2_frame_rx #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_rx (
        .clk        (clk),
        .res        (res),
        .ps2_clk    (bus.ps2_clk),
        .ps2_data   (bus.ps2_data),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .frame_err  (bus.frame_err),
        .par_err    (par_err)
    );

    logic [15:0] keys_q, keys_d;
    logic        key_event_q, key_event_d;
    logic [3:0]  key_code_q, key_code_d;
    logic        key_down_q, key_down_d;
    logic        ext_q, ext_d;
    logic        brk_q, brk_d;
    key_map_t    km;

    always_comb begin
        keys_d      = keys_q;
        key_event_d = 1'b0;
        key_code_d  = key_code_q;
        key_down_d  = key_down_q;
        ext_d       = ext_q;
        brk_d       = brk_q;
        km          = map_key(rx_byte);
        // A corrupted frame may have been a prefix; forget pending ones
        if (par_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end
        if (byte_valid) begin
            unique case (1'b1)
                (rx_byte == SC_E0): ext_d = 1'b1;
                (rx_byte == SC_F0): brk_d = 1'b1;
                default: begin
                    if (!ext_q && km.hit) begin
                        keys_d[km.code] = ~brk_q;
                        key_event_d     = 1'b1;
                        key_code_d      = km.code;
                        key_down_d      = ~brk_q;
                    end
                    ext_d = 1'b0;
                    brk_d = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (res) begin
            keys_q      <= '0;
            key_event_q <= 1'b0;
            key_code_q  <= '0;
            key_down_q  <= 1'b0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
        end else begin
            keys_q      <= keys_d;
            key_event_q <= key_event_d;
            key_code_q  <= key_code_d;
            key_down_q  <= key_down_d;
            ext_q       <= ext_d;
            brk_q       <= brk_d;
        end
    end

    assign bus.keys      = keys_q;
    assign bus.key_event = key_event_q;
    assign bus.key_code  = key_code_q;
    assign bus.key_down  = key_down_q;

endmodule

// File: tb/tb_ps2_keypad.sv
// Self-checking bench for ps2_keypad: directed scenarios plus random
// scancode streams checked against a keypad model.
module tb_ps2_keypad;

    localparam int TMO = 2000;
    localparam int H   = 50;

    logic clk = 1'b0;
    logic res = 1'b1;

    ps2_keypad_if bus();

    ps2_keypad #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk (clk),
        .res (res),
        .bus (bus)
    );

    always #20 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          ev_cnt  = 0;
    int          err_cnt = 0;
    int          ev_cyc  = 0;
    logic [15:0] ev_keys = '0;

    always @(negedge clk) begin
        if (bus.key_event === 1'b1) begin
            ev_cnt++;
            ev_cyc  = cyc;
            ev_keys = bus.keys;
        end
        if (bus.frame_err === 1'b1) err_cnt++;
    end

    int n_tests  = 0;
    int n_fail   = 0;
    int stop_cyc = 0;

    logic [15:0] m_keys;
    logic [3:0]  m_code;
    bit          m_down, m_ext, m_brk;
    logic [7:0]  sc_tab [16] = '{
        8'h22, 8'h16, 8'h1E, 8'h26, 8'h15, 8'h1D, 8'h24, 8'h1C,
        8'h1B, 8'h23, 8'h1A, 8'h21, 8'h25, 8'h2D, 8'h2B, 8'h2A
    };

    task automatic model_reset();
        m_keys = '0;
        m_code = '0;
        m_down = 0;
        m_ext  = 0;
        m_brk  = 0;
    endtask

    task automatic model_byte(input logic [7:0] b, output int ev);
        ev = 0;
        if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin
            if (!m_ext)
                for (int n = 0; n < 16; n++)
                    if (sc_tab[n] == b) begin
                        m_keys[n] = !m_brk;
                        m_code    = 4'(n);
                        m_down    = !m_brk;
                        ev        = 1;
                    end
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par,
                        input bit bad_stop, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            bus.ps2_data = f[i];
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b0;
            if (i == 10) stop_cyc = cyc;
            repeat (H) @(negedge clk);
            bus.ps2_clk = 1'b1;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic good(input logic [7:0] b, output int ev);
        send(b, 0, 0, 11);
        model_byte(b, ev);
    endtask

    task automatic test_reset();
        res = 1'b1;
        repeat (5) @(negedge clk);
        n_tests += 5;
        if (bus.keys !== 16'h0) begin
            n_fail++; $display("FAIL rst_keys got %h want 0000", bus.keys);
        end
        if (bus.key_event !== 1'b0) begin
            n_fail++; $display("FAIL rst_event got %b want 0", bus.key_event);
        end
        if (bus.key_code !== 4'h0) begin
            n_fail++; $display("FAIL rst_code got %h want 0", bus.key_code);
        end
        if (bus.key_down !== 1'b0) begin
            n_fail++; $display("FAIL rst_down got %b want 0", bus.key_down);
        end
        if (bus.frame_err !== 1'b0) begin
            n_fail++; $display("FAIL rst_err got %b want 0", bus.frame_err);
        end
        res = 1'b0;
        model_reset();
        repeat (5) @(negedge clk);
    endtask

    task automatic test_make();
        int e0, ev;
        e0 = ev_cnt;
        good(8'h1C, ev);
        n_tests += 6;
        if (ev_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL make_events got %0d want 1", ev_cnt - e0);
        end
        if (bus.keys !== 16'h0080) begin
            n_fail++; $display("FAIL make_keys got %h want 0080", bus.keys);
        end
        if (ev_keys !== 16'h0080) begin
            n_fail++; $display("FAIL make_keys_at_event got %h want 0080", ev_keys);
        end
        if (bus.key_code !== 4'h7) begin
            n_fail++; $display("FAIL make_code got %h want 7", bus.key_code);
        end
        if (bus.key_down !== 1'b1) begin
            n_fail++; $display("FAIL make_down got %b want 1", bus.key_down);
        end
        // two sync flops, frame FSM, then the decode register
        if (ev_cyc - stop_cyc !== 4) begin
            n_fail++;
            $display("FAIL make_latency got %0d want 4", ev_cyc - stop_cyc);
        end
    endtask

    task automatic test_break();
        int e0, ev;
        e0 = ev_cnt;
        good(8'hF0, ev);
        good(8'h1C, ev);
        n_tests += 4;
        if (ev_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL brk_events got %0d want 1", ev_cnt - e0);
        end
        if (bus.keys !== 16'h0000) begin
            n_fail++; $display("FAIL brk_keys got %h want 0000", bus.keys);
        end
        if (bus.key_code !== 4'h7) begin
            n_fail++; $display("FAIL brk_code got %h want 7", bus.key_code);
        end
        if (bus.key_down !== 1'b0) begin
            n_fail++; $display("FAIL brk_down got %b want 0", bus.key_down);
        end
    endtask

    task automatic test_ext();
        int e0, ev;
        e0 = ev_cnt;
        good(8'hE0, ev);
        good(8'h75, ev);
        n_tests += 1;
        if (ev_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL ext_events got %0d want 0", ev_cnt - e0);
        end
        e0 = ev_cnt;
        good(8'h22, ev);
        n_tests += 3;
        if (ev_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL x_events got %0d want 1", ev_cnt - e0);
        end
        if (bus.keys !== 16'h0001) begin
            n_fail++; $display("FAIL x_keys got %h want 0001", bus.keys);
        end
        if (bus.key_code !== 4'h0) begin
            n_fail++; $display("FAIL x_code got %h want 0", bus.key_code);
        end
    endtask

    task automatic test_parity();
        int e0, r0, ev;
        e0 = ev_cnt;
        r0 = err_cnt;
        send(8'h16, 1, 0, 11);
        m_ext = 0; m_brk = 0;
        n_tests += 3;
        if (err_cnt - r0 !== 1) begin
            n_fail++; $display("FAIL par_err got %0d want 1", err_cnt - r0);
        end
        if (ev_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL par_events got %0d want 0", ev_cnt - e0);
        end
        if (bus.keys !== 16'h0001) begin
            n_fail++; $display("FAIL par_keys got %h want 0001", bus.keys);
        end
        r0 = err_cnt;
        send(8'hF0, 1, 0, 11);
        m_ext = 0; m_brk = 0;
        good(8'h16, ev);
        n_tests += 4;
        if (err_cnt - r0 !== 1) begin
            n_fail++; $display("FAIL lostf0_err got %0d want 1", err_cnt - r0);
        end
        if (bus.keys !== 16'h0003) begin
            n_fail++; $display("FAIL lostf0_keys got %h want 0003", bus.keys);
        end
        if (bus.key_down !== 1'b1) begin
            n_fail++; $display("FAIL lostf0_down got %b want 1", bus.key_down);
        end
        if (bus.key_code !== 4'h1) begin
            n_fail++; $display("FAIL lostf0_code got %h want 1", bus.key_code);
        end
    endtask

    task automatic test_timeout();
        int e0, r0, ev;
        e0 = ev_cnt;
        r0 = err_cnt;
        send(8'h2A, 0, 0, 5);
        repeat (TMO + 200) @(negedge clk);
        n_tests += 3;
        if (err_cnt - r0 !== 1) begin
            n_fail++; $display("FAIL tmo_err got %0d want 1", err_cnt - r0);
        end
        if (ev_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL tmo_events got %0d want 0", ev_cnt - e0);
        end
        if (bus.keys !== 16'h0003) begin
            n_fail++; $display("FAIL tmo_keys got %h want 0003", bus.keys);
        end
        good(8'h2A, ev);
        n_tests += 2;
        if (bus.keys !== 16'h8003) begin
            n_fail++; $display("FAIL tmo_next_keys got %h want 8003", bus.keys);
        end
        if (bus.key_code !== 4'hF) begin
            n_fail++; $display("FAIL tmo_next_code got %h want F", bus.key_code);
        end
    endtask

    task automatic test_reset_mid();
        int e0, r0, ev;
        good(8'h25, ev);
        good(8'h2D, ev);
        n_tests += 1;
        if (bus.keys !== 16'hB003) begin
            n_fail++; $display("FAIL hold_keys got %h want b003", bus.keys);
        end
        e0 = ev_cnt;
        r0 = err_cnt;
        send(8'h1B, 0, 0, 3);
        res = 1'b1;
        repeat (3) @(negedge clk);
        n_tests += 3;
        if (bus.keys !== 16'h0) begin
            n_fail++; $display("FAIL midrst_keys got %h want 0000", bus.keys);
        end
        if (bus.key_code !== 4'h0) begin
            n_fail++; $display("FAIL midrst_code got %h want 0", bus.key_code);
        end
        if (bus.key_down !== 1'b0) begin
            n_fail++; $display("FAIL midrst_down got %b want 0", bus.key_down);
        end
        res = 1'b0;
        model_reset();
        repeat (TMO + 200) @(negedge clk);
        n_tests += 2;
        if (err_cnt - r0 !== 0) begin
            n_fail++; $display("FAIL midrst_err got %0d want 0", err_cnt - r0);
        end
        if (ev_cnt - e0 !== 0) begin
            n_fail++; $display("FAIL midrst_events got %0d want 0", ev_cnt - e0);
        end
        good(8'h1B, ev);
        n_tests += 2;
        if (bus.keys !== 16'h0100) begin
            n_fail++; $display("FAIL midrst_next_keys got %h want 0100", bus.keys);
        end
        if (bus.key_code !== 4'h8) begin
            n_fail++; $display("FAIL midrst_next_code got %h want 8", bus.key_code);
        end
    endtask

    task automatic test_random();
        int e0, r0, ev, sel;
        logic [7:0] b;
        bit bad;
        for (int it = 0; it < 30; it++) begin
            sel = $urandom_range(0, 9);
            bad = (sel == 9);
            case (sel)
                5, 6:    b = 8'hF0;
                7:       b = 8'hE0;
                8:       b = 8'($urandom);
                default: b = sc_tab[$urandom_range(0, 15)];
            endcase
            e0 = ev_cnt;
            r0 = err_cnt;
            send(b, bad, 0, 11);
            if (bad) begin
                ev = 0; m_ext = 0; m_brk = 0;
            end else begin
                model_byte(b, ev);
            end
            n_tests += 3;
            if (bus.keys !== m_keys) begin
                n_fail++;
                $display("FAIL rnd%0d_keys byte %h got %h want %h", it, b, bus.keys, m_keys);
            end
            if (ev_cnt - e0 !== ev) begin
                n_fail++;
                $display("FAIL rnd%0d_events byte %h got %0d want %0d", it, b, ev_cnt - e0, ev);
            end
            if (err_cnt - r0 !== int'(bad)) begin
                n_fail++;
                $display("FAIL rnd%0d_err byte %h got %0d want %0d", it, b, err_cnt - r0, bad);
            end
            if (ev == 1) begin
                n_tests += 1;
                if ({bus.key_code, bus.key_down} !== {m_code, m_down}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_code got %h/%b want %h/%b", it,
                             bus.key_code, bus.key_down, m_code, m_down);
                end
            end
        end
    endtask

    initial begin
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        model_reset();
        test_reset();
        test_make();
        test_break();
        test_ext();
        test_parity();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
